st_addsub_mc: RTL and testbench
===============================

# st_addsub_mc

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, using an internal DIGIT-bit ripple full-adder chain with the carry registered between digits. It generalises the combinational 4-bit full-adder chain to arbitrary width, adds subtract mode, overflow detection and a start/busy/done handshake. It sits in datapaths that trade latency for a small adder.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. CYCLES = WIDTH/DIGIT.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0: S=A+B+ci; 1: S=A−B (ci ignored).
- ci  in  1  carry-in for add mode.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: s/co/ovf just updated.
- s  out  WIDTH  result, registered, held until next completion.
- co  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN. done is a registered flag, not a state.
- IDLE, start=1 at edge: latch a into op_a; latch b (sub=0) or ~b (sub=1) into op_b; carry ← sub ? 1 : ci; digit counter ← 0; → RUN; busy=1.
- IDLE, start=0: stay; done ← 0.
- RUN, each edge: add digit k (bits k·DIGIT+DIGIT−1 .. k·DIGIT) of op_a, op_b plus carry through DIGIT-bit ripple chain; sum digit into internal result register at position k; carry ← chain carry-out; k ← k+1.
- On the edge processing k = CYCLES−1: s ← full result; co ← chain carry-out; ovf ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1; done ← 1; busy ← 0; → IDLE.
- s/co/ovf never show partial results; they change only on completion edges and reset.
- start while busy=1: ignored, no queueing; a/b/sub/ci changes during RUN have no effect.
- Width rule: result modulo 2^WIDTH; no sign extension; co and ovf are the only extra bits.
- DIGIT=WIDTH: CYCLES=1, a single RUN edge. DIGIT=1: bit-serial.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, s=0, co=0, ovf=0, internal registers 0.
- Start edge E0: busy=1 after E0. Digit edges E1..E_CYCLES. After E_CYCLES: done=1, busy=0, results valid. Latency start-to-done = CYCLES+1 edges counting E0.
- done high exactly one cycle; it clears on the next edge unless that edge completes another operation, which cannot occur before CYCLES+1 edges.
- Back-to-back: start=1 during the done cycle (busy=0) is accepted; the next done follows CYCLES+1 edges later. Throughput: one result per CYCLES+1 cycles.
- Reset mid-RUN: operation aborted, no done pulse, outputs cleared; start is accepted on the first edge after rst deasserts.
- rst asserted in the same cycle as start: reset wins.

## Test plan
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0FFF, sub=0, ci=0, start 1 cycle -> busy high 4 cycles, done pulse on 5th edge, s=0x2233, co=0, ovf=0.
- a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Same with ci=1 -> s=0x0001, co=1.
- a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, co=0, ovf=1. Sub a=0x8000, b=0x0001 -> s=0x7FFF, co=1, ovf=1.
- sub=1, ci=1, a=0x0005, b=0x0007 -> s=0xFFFE, co=0, ovf=0 (ci ignored). Pulse start again mid-RUN with new operands -> ignored, result unchanged.
- Back-to-back: start held high continuously -> done every 5th cycle, each s matching the operands sampled at its start edge.
- rst pulse at the 2nd RUN edge of 0x1234+0x0FFF -> s/co/ovf/busy/done=0 immediately, no done; a subsequent 0x0001+0x0001 gives s=0x0002. Repeat the first case with DIGIT=1 (done after 17 edges) and DIGIT=16 (done after 2 edges).

Source files
------------

// File: rtl/st_addsub_mc_if.sv
// Handshake/operand bundle for st_addsub_mc.
// master: drives start/sub/ci/a/b and observes busy/done/s/co/ovf.
// slave : the adder side, the reverse directions.
interface st_addsub_mc_if #(
   parameter int WIDTH = 16
);
   logic             start;  // request, sampled only while busy is low
   logic             sub;    // 0: a+b+ci, 1: a-b
   logic             ci;     // carry-in, add mode only
   logic [WIDTH-1:0] a;      // operand A
   logic [WIDTH-1:0] b;      // operand B
   logic             busy;   // operation in progress
   logic             done;   // one-cycle pulse, s/co/ovf just updated
   logic [WIDTH-1:0] s;      // registered result
   logic             co;     // carry out of MSB (sub: 1 = no borrow)
   logic             ovf;    // two's-complement overflow

   modport master (
      output start, sub, ci, a, b,
      input  busy, done, s, co, ovf
   );

   modport slave (
      input  start, sub, ci, a, b,
      output busy, done, s, co, ovf
   );
endinterface

// File: rtl/st_addsub_mc.sv
// Multi-cycle add/subtract, DIGIT bits per clock through a DIGIT-bit ripple chain.
// Latency: CYCLES+1 edges from the accepting start edge to done (CYCLES = WIDTH/DIGIT).
// Backpressure: none queued; start is ignored while busy, one result per CYCLES+1 cycles.
//
// Ports: clk, rst (async, active-high) and bus (slave side of st_addsub_mc_if):
//   start/sub/ci/a/b in, busy/done/s/co/ovf out. s/co/ovf only change on completion or reset.
module st_addsub_mc #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   st_addsub_mc_if.slave bus
);

   localparam int CYCLES = WIDTH / DIGIT;
   localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   localparam logic [0:0]    ST_IDLE = 1'b0;
   localparam logic [0:0]    ST_RUN  = 1'b1;
   localparam logic [CW-1:0] LAST_K  = CW'(CYCLES - 1);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] op_a_q,  op_a_d;
   logic [WIDTH-1:0] op_b_q,  op_b_d;   // already inverted for subtract
   logic             carry_q, carry_d;  // carry between digits
   logic [CW-1:0]    cnt_q,   cnt_d;    // digit index k
   logic [WIDTH-1:0] res_q,   res_d;    // partial result, never visible outside
   logic [WIDTH-1:0] s_q,     s_d;
   logic             co_q,    co_d;
   logic             ovf_q,   ovf_d;
   logic             done_q,  done_d;

   // Digit slice and ripple chain
   int               base;
   logic [DIGIT-1:0] dig_a;
   logic [DIGIT-1:0] dig_b;
   logic [DIGIT-1:0] dig_s;
   logic [DIGIT:0]   chain_c;

   always_comb begin
      base       = int'(cnt_q) * DIGIT;
      dig_a      = op_a_q[base +: DIGIT];
      dig_b      = op_b_q[base +: DIGIT];
      dig_s      = '0;
      chain_c    = '0;
      chain_c[0] = carry_q;
      for (int i = 0; i < DIGIT; i++) begin
         dig_s[i]      = dig_a[i] ^ dig_b[i] ^ chain_c[i];
         chain_c[i+1]  = (dig_a[i] & dig_b[i]) | (chain_c[i] & (dig_a[i] ^ dig_b[i]));
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_a_d  = bus.a;
               // Subtract as a + ~b + 1: the +1 enters as the initial carry.
               op_b_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.ci;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d[base +: DIGIT] = dig_s;
            carry_d              = chain_c[DIGIT];
            if (cnt_q == LAST_K) begin
               s_d     = res_d;
               co_d    = chain_c[DIGIT];
               // Last digit holds the MSB: carry into vs. out of bit WIDTH-1.
               ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = done_q;
   assign bus.s    = s_q;
   assign bus.co   = co_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_st_addsub_mc.sv
// Bench for st_addsub_mc: WIDTH=16 with DIGIT=4 (unit 0), DIGIT=1 (unit 1), DIGIT=16 (unit 2).
// Directed cases plus random operands compared against an integer-arithmetic reference.
// Summary line reports passed/total checks.
module tb_st_addsub_mc;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   st_addsub_mc_if #(.WIDTH(16)) if4  ();
   st_addsub_mc_if #(.WIDTH(16)) if1  ();
   st_addsub_mc_if #(.WIDTH(16)) if16 ();

   st_addsub_mc #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
   st_addsub_mc #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
   st_addsub_mc #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

   logic        start_v [3];
   logic        sub_v   [3];
   logic        ci_v    [3];
   logic [15:0] a_v     [3];
   logic [15:0] b_v     [3];
   logic        busy_w  [3];
   logic        done_w  [3];
   logic [15:0] s_w     [3];
   logic        co_w    [3];
   logic        ovf_w   [3];

   assign if4.start  = start_v[0];
   assign if4.sub    = sub_v[0];
   assign if4.ci     = ci_v[0];
   assign if4.a      = a_v[0];
   assign if4.b      = b_v[0];
   assign if1.start  = start_v[1];
   assign if1.sub    = sub_v[1];
   assign if1.ci     = ci_v[1];
   assign if1.a      = a_v[1];
   assign if1.b      = b_v[1];
   assign if16.start = start_v[2];
   assign if16.sub   = sub_v[2];
   assign if16.ci    = ci_v[2];
   assign if16.a     = a_v[2];
   assign if16.b     = b_v[2];

   assign busy_w[0] = if4.busy;
   assign done_w[0] = if4.done;
   assign s_w[0]    = if4.s;
   assign co_w[0]   = if4.co;
   assign ovf_w[0]  = if4.ovf;
   assign busy_w[1] = if1.busy;
   assign done_w[1] = if1.done;
   assign s_w[1]    = if1.s;
   assign co_w[1]   = if1.co;
   assign ovf_w[1]  = if1.ovf;
   assign busy_w[2] = if16.busy;
   assign done_w[2] = if16.done;
   assign s_w[2]    = if16.s;
   assign co_w[2]   = if16.co;
   assign ovf_w[2]  = if16.ovf;

   int passed = 0;
   int total  = 0;

   function automatic int cyc_of(input int u);
      return (u == 0) ? 4 : ((u == 1) ? 16 : 1);
   endfunction

   // Reference from integer arithmetic: returns {ovf, co, s}.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic sub, input logic ci);
      int ua, ub, sa, sb, us, ss;
      logic co, ovf;
      logic [15:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!sub) begin
         us = ua + ub + int'(ci);
         ss = sa + sb + int'(ci);
         co = (us > 65535);
      end else begin
         us = ua - ub;
         ss = sa - sb;
         co = (ua >= ub);
      end
      s   = 16'(us);
      ovf = (ss > 32767) || (ss < -32768);
      return {ovf, co, s};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One operation on unit u; operands are scrambled during RUN to show they are not re-sampled.
   task automatic do_op(input int u, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic ci, input logic [15:0] es,
                        input logic eco, input logic eovf, input string tag);
      int n, nb;
      bit got;
      @(negedge clk);
      a_v[u] = a; b_v[u] = b; sub_v[u] = sub; ci_v[u] = ci; start_v[u] = 1'b1;
      n = 0; nb = 0; got = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         start_v[u] = 1'b0;
         a_v[u] = 16'($urandom); b_v[u] = 16'($urandom);
         sub_v[u] = 1'($urandom); ci_v[u] = 1'($urandom);
         n++;
         if (done_w[u]) got = 1;
         else if (busy_w[u]) nb++;
      end
      check({tag, ":latency"}, n, cyc_of(u) + 1);
      check({tag, ":busy_cycles"}, nb, cyc_of(u));
      check({tag, ":s"}, s_w[u], es);
      check({tag, ":co"}, co_w[u], eco);
      check({tag, ":ovf"}, ovf_w[u], eovf);
      check({tag, ":busy_at_done"}, busy_w[u], 0);
      @(negedge clk);
      check({tag, ":done_one_cycle"}, done_w[u], 0);
   endtask

   task automatic rnd_op(input int u, input string tag);
      logic [15:0] a, b;
      logic sub, ci;
      logic [17:0] m;
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom); ci = 1'($urandom);
      m = model(a, b, sub, ci);
      do_op(u, a, b, sub, ci, m[15:0], m[16], m[17], tag);
   endtask

   initial begin
      int n, nd, cnt, guard, nbusy;
      logic [15:0] pa, pb;
      logic psub, pci;
      logic [17:0] m;

      for (int u = 0; u < 3; u++) begin
         start_v[u] = 0; sub_v[u] = 0; ci_v[u] = 0; a_v[u] = '0; b_v[u] = '0;
      end
      rst = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst:busy", busy_w[0], 0);
      check("rst:done", done_w[0], 0);
      check("rst:s", s_w[0], 0);
      check("rst:co", co_w[0], 0);
      check("rst:ovf", ovf_w[0], 0);
      rst = 1'b0;

      // Directed cases, DIGIT=4
      do_op(0, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, "add_basic");
      do_op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "add_wrap");
      do_op(0, 16'hFFFF, 16'h0001, 0, 1, 16'h0001, 1, 0, "add_wrap_ci");
      do_op(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "add_ovf");
      do_op(0, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, "sub_ovf");

      // Subtract ignores ci; a second start during RUN is dropped, not queued.
      @(negedge clk);
      a_v[0] = 16'h0005; b_v[0] = 16'h0007; sub_v[0] = 1; ci_v[0] = 1; start_v[0] = 1;
      @(negedge clk);
      check("ign:busy_after_start", busy_w[0], 1);
      a_v[0] = 16'h1111; b_v[0] = 16'h2222; sub_v[0] = 0; ci_v[0] = 0; start_v[0] = 1;
      @(negedge clk);
      start_v[0] = 0;
      n = 2;
      while (!done_w[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ign:latency", n, 5);
      check("ign:s", s_w[0], 16'hFFFE);
      check("ign:co", co_w[0], 0);
      check("ign:ovf", ovf_w[0], 0);
      nbusy = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy_w[0] || done_w[0]) nbusy++;
      end
      check("ign:no_queued_op", nbusy, 0);
      check("ign:s_held", s_w[0], 16'hFFFE);

      // Random operations, DIGIT=4
      for (int i = 0; i < 12; i++) rnd_op(0, "rnd4");

      // Back-to-back with start held high
      @(negedge clk);
      pa = 16'($urandom); pb = 16'($urandom); psub = 1'($urandom); pci = 1'($urandom);
      a_v[0] = pa; b_v[0] = pb; sub_v[0] = psub; ci_v[0] = pci; start_v[0] = 1;
      nd = 0; cnt = 0; guard = 0;
      while (nd < 6 && guard < 200) begin
         @(negedge clk);
         guard++;
         cnt++;
         if (done_w[0]) begin
            m = model(pa, pb, psub, pci);
            check("b2b:latency", cnt, 5);
            check("b2b:s", s_w[0], m[15:0]);
            check("b2b:co", co_w[0], m[16]);
            check("b2b:ovf", ovf_w[0], m[17]);
            nd++;
            cnt = 0;
            if (nd == 6) begin
               start_v[0] = 0;
            end else begin
               pa = 16'($urandom); pb = 16'($urandom); psub = 1'($urandom); pci = 1'($urandom);
               a_v[0] = pa; b_v[0] = pb; sub_v[0] = psub; ci_v[0] = pci;
            end
         end else begin
            a_v[0] = 16'($urandom); b_v[0] = 16'($urandom);
            sub_v[0] = 1'($urandom); ci_v[0] = 1'($urandom);
         end
      end
      start_v[0] = 0;
      check("b2b:results", nd, 6);
      @(negedge clk);
      check("b2b:idle_after", busy_w[0], 0);

      // Reset in the middle of a run
      do_op(0, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, "pre_rst");
      a_v[0] = 16'h1234; b_v[0] = 16'h0FFF; sub_v[0] = 0; ci_v[0] = 0; start_v[0] = 1;
      @(negedge clk);
      start_v[0] = 0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst:s", s_w[0], 0);
      check("mid_rst:co", co_w[0], 0);
      check("mid_rst:ovf", ovf_w[0], 0);
      check("mid_rst:busy", busy_w[0], 0);
      check("mid_rst:done", done_w[0], 0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0; nbusy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done_w[0]) nd++;
         if (busy_w[0]) nbusy++;
      end
      check("mid_rst:no_done", nd, 0);
      check("mid_rst:no_busy", nbusy, 0);
      do_op(0, 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, "post_rst");

      // Reset wins over a simultaneous start; start right after release is accepted.
      @(negedge clk);
      a_v[0] = 16'h0002; b_v[0] = 16'h0003; sub_v[0] = 0; ci_v[0] = 0; start_v[0] = 1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_start:busy", busy_w[0], 0);
      rst = 1'b0;
      @(negedge clk);
      start_v[0] = 0;
      check("rst_start:accepted", busy_w[0], 1);
      n = 1;
      while (!done_w[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("rst_start:latency", n, 5);
      check("rst_start:s", s_w[0], 16'h0005);

      // Bit-serial and single-cycle variants
      do_op(1, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, "d1_basic");
      do_op(1, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, "d1_sub_ovf");
      for (int i = 0; i < 4; i++) rnd_op(1, "rnd1");
      do_op(2, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, "d16_basic");
      do_op(2, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "d16_ovf");
      for (int i = 0; i < 6; i++) rnd_op(2, "rnd16");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
